// File: rtl/hazard_ctrl_pkg.sv
// Shared control definitions for the hazard controller.
// FSM encodings, decode class codes and flush limits.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] SEL_INVALID = 5'd0;

  localparam int FLUSH_MAX = 7;
  localparam int FCNT_W    = 3;

  function automatic logic [FCNT_W-1:0] flush_load(
    input int cycles
  );
    return FCNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use register compare between EX and ID.
// Purely combinational.
module hazard_detect #(
  parameter int REG_W = 3
) (
  input  logic             ex_is_load,
  input  logic             ex_rd_we,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_use
);

  logic hit1;
  logic hit2;

  assign hit1 = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit2 = id_use_rs2 & (id_rs2 == ex_rd);

  assign load_use = ex_is_load & ex_rd_we
                  & id_valid & (hit1 | hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes,
// memory freeze, illegal-op flag and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_select,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic             ex_rd_we,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pipe_freeze,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > FLUSH_MAX) begin : g_bad_flush
    $error("FLUSH_CYCLES out of range");
  end

  state_t            state;
  state_t            saved_state;
  logic [FCNT_W-1:0] fcnt;
  logic [FCNT_W-1:0] saved_cnt;

  state_t            eff_state;
  logic [FCNT_W-1:0] eff_cnt;
  state_t            nxt_state;
  logic [FCNT_W-1:0] nxt_cnt;

  logic load_use;
  logic set_illegal;
  logic br_evt;

  logic pc_stall_c;
  logic if_id_stall_c;
  logic bubble_c;
  logic flush_if_c;
  logic flush_ex_c;
  logic freeze_c;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_detect (
    .ex_is_load (ex_is_load),
    .ex_rd_we   (ex_rd_we),
    .ex_rd      (ex_rd),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .load_use   (load_use)
  );

  // Resolve events by priority; MEM_WAIT acts as the saved state once busy drops
  always_comb begin
    eff_state     = state;
    eff_cnt       = fcnt;
    if (state == MEM_WAIT) begin
      eff_state = saved_state;
      eff_cnt   = saved_cnt;
    end
    nxt_state     = eff_state;
    nxt_cnt       = eff_cnt;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    bubble_c      = 1'b0;
    flush_if_c    = 1'b0;
    flush_ex_c    = 1'b0;
    freeze_c      = 1'b0;
    set_illegal   = 1'b0;
    br_evt        = 1'b0;
    if (mem_busy) begin
      freeze_c      = 1'b1;
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      nxt_state     = MEM_WAIT;
      nxt_cnt       = fcnt;
    end else if (ex_br_taken) begin
      flush_if_c = 1'b1;
      flush_ex_c = 1'b1;
      br_evt     = 1'b1;
      nxt_cnt    = flush_load(FLUSH_CYCLES);
      nxt_state  = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
    end else if (eff_state == BR_FLUSH) begin
      flush_if_c = 1'b1;
      if (eff_cnt <= FCNT_W'(1)) begin
        nxt_cnt   = '0;
        nxt_state = RUN;
      end else begin
        nxt_cnt = eff_cnt - FCNT_W'(1);
      end
    end else if (load_use) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      bubble_c      = 1'b1;
    end else if (id_valid && id_select == SEL_INVALID) begin
      flush_if_c  = 1'b1;
      set_illegal = 1'b1;
    end
  end

  assign pc_stall     = rst_n & pc_stall_c;
  assign if_id_stall  = rst_n & if_id_stall_c;
  assign id_ex_bubble = rst_n & bubble_c;
  assign flush_if_id  = rst_n & flush_if_c;
  assign flush_id_ex  = rst_n & flush_ex_c;
  assign pipe_freeze  = rst_n & freeze_c;

  // FSM state, flush counter and the context saved across a memory wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fcnt        <= '0;
      saved_state <= RUN;
      saved_cnt   <= '0;
    end else begin
      state <= nxt_state;
      fcnt  <= nxt_cnt;
      if (mem_busy && state != MEM_WAIT) begin
        saved_state <= state;
        saved_cnt   <= fcnt;
      end
    end
  end

  // Sticky illegal flag and saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (set_illegal) illegal_op <= 1'b1;
      if (pc_stall_c && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (br_evt && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// ctl = {pc_stall,if_id_stall,bubble,flush_if,flush_ex,freeze}
module tb_hazard_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_select;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             ex_is_load;
  logic             ex_rd_we;
  logic [REG_W-1:0] ex_rd;
  logic             ex_br_taken;
  logic             mem_busy;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             pipe_freeze;
  logic             illegal_op;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [5:0]       ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_stall, if_id_stall, id_ex_bubble,
                flush_if_id, flush_id_ex, pipe_freeze};

  hazard_ctrl #(
    .REG_W        (REG_W),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_select    (id_select),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_is_load   (ex_is_load),
    .ex_rd_we     (ex_rd_we),
    .ex_rd        (ex_rd),
    .ex_br_taken  (ex_br_taken),
    .mem_busy     (mem_busy),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .id_ex_bubble (id_ex_bubble),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .pipe_freeze  (pipe_freeze),
    .illegal_op   (illegal_op),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_select   = 5'd1;
    id_rs1      = '0;
    id_rs2      = '0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd_we    = 1'b0;
    ex_rd       = '0;
    ex_br_taken = 1'b0;
    mem_busy    = 1'b0;
  endtask

  task automatic lu(input logic rs2_path, input logic use_it);
    idle();
    id_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd_we   = 1'b1;
    ex_rd      = 3'd3;
    if (rs2_path) begin
      id_rs2     = 3'd3;
      id_use_rs2 = use_it;
    end else begin
      id_rs1     = 3'd3;
      id_use_rs1 = use_it;
    end
  endtask

  // inputs already set; check mid-cycle, then advance past next edge
  task automatic cyc(input string tag, input logic [5:0] exp);
    #2;
    chk(tag, 32'(ctl), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n     = 1'b0;
    id_valid  = 1'b1;
    id_select = 5'd0;
    ex_br_taken = 1'b1;
    #12;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_illegal", 32'(illegal_op), 32'h0);
    chk("rst_scnt", 32'(stall_cnt), 32'h0);
    chk("rst_fcnt", 32'(flush_cnt), 32'h0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lu(1'b0, 1'b1);
    cyc("lu_rs1", 6'b111000);
    idle();
    cyc("lu_rs1_after", 6'b000000);
    chk("scnt_1", 32'(stall_cnt), 32'd1);

    lu(1'b1, 1'b0);
    cyc("rs2_unused", 6'b000000);
    lu(1'b1, 1'b1);
    cyc("lu_rs2", 6'b111000);
    lu(1'b0, 1'b1);
    ex_rd_we = 1'b0;
    cyc("load_no_we", 6'b000000);
    lu(1'b0, 1'b1);
    ex_rd = 3'd4;
    cyc("lu_diff_rd", 6'b000000);
    chk("scnt_2", 32'(stall_cnt), 32'd2);

    idle();
    ex_br_taken = 1'b1;
    cyc("br_c0", 6'b000110);
    idle();
    cyc("br_c1", 6'b000100);
    cyc("br_c2", 6'b000000);
    chk("fcnt_1", 32'(flush_cnt), 32'd1);

    lu(1'b0, 1'b1);
    ex_br_taken = 1'b1;
    cyc("br_lu_c0", 6'b000110);
    idle();
    cyc("br_lu_c1", 6'b000100);
    cyc("br_lu_c2", 6'b000000);
    chk("br_lu_scnt", 32'(stall_cnt), 32'd2);
    chk("fcnt_2", 32'(flush_cnt), 32'd2);

    idle();
    ex_br_taken = 1'b1;
    cyc("brm_c0", 6'b000110);
    idle();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cyc("brm_frz", 6'b110001);
    idle();
    cyc("brm_rest", 6'b000100);
    cyc("brm_run", 6'b000000);
    chk("brm_scnt", 32'(stall_cnt), 32'd5);
    chk("fcnt_3", 32'(flush_cnt), 32'd3);

    idle();
    ex_br_taken = 1'b1;
    cyc("rebr_c0", 6'b000110);
    cyc("rebr_c1", 6'b000110);
    idle();
    cyc("rebr_c2", 6'b000100);
    cyc("rebr_c3", 6'b000000);
    chk("fcnt_5", 32'(flush_cnt), 32'd5);

    lu(1'b0, 1'b1);
    ex_br_taken = 1'b1;
    mem_busy = 1'b1;
    cyc("mem_pri", 6'b110001);
    idle();
    cyc("mem_pri_run", 6'b000000);
    chk("scnt_6", 32'(stall_cnt), 32'd6);
    chk("fcnt_hold", 32'(flush_cnt), 32'd5);

    idle();
    id_valid  = 1'b1;
    id_select = 5'd0;
    ex_br_taken = 1'b1;
    cyc("ill_br", 6'b000110);
    chk("ill_br_flag", 32'(illegal_op), 32'h0);
    idle();
    cyc("ill_br_c1", 6'b000100);

    idle();
    id_valid  = 1'b1;
    id_select = 5'd0;
    cyc("ill_c0", 6'b000100);
    chk("ill_set", 32'(illegal_op), 32'h1);
    idle();
    cyc("ill_c1", 6'b000000);
    id_select = 5'd0;
    cyc("ill_novalid", 6'b000000);
    chk("ill_sticky", 32'(illegal_op), 32'h1);

    idle();
    ex_br_taken = 1'b1;
    cyc("rst_br", 6'b000110);
    idle();
    #2;
    chk("rst_midflush", 32'(ctl), 32'b000100);
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", 32'(ctl), 32'h0);
    chk("arst_illegal", 32'(illegal_op), 32'h0);
    chk("arst_scnt", 32'(stall_cnt), 32'h0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc("arst_norfl", 6'b000000);
    chk("arst_ill_low", 32'(illegal_op), 32'h0);

    lu(1'b0, 1'b1);
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_scnt", 32'(stall_cnt), 32'hFFFF);
    cyc("sat_stall", 6'b111000);
    chk("sat_hold", 32'(stall_cnt), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
